// File: rtl/sar_ctrl_pkg.sv
// Shared definitions for the SAR ADC conversion sequencer.
//   - state_t      : FSM state encoding (3-bit)
//   - SAR_*        : default conversion parameters
//   - bit_idx_w()  : width of the bit-under-evaluation index
//   - timer_w()    : width of the shared down-counter
package sar_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_ARM    = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SAR_N_BITS        = 8;
    localparam int SAR_SAMPLE_CYCLES = 4;
    localparam int SAR_TIMEOUT       = 15;

    // Index width; a single-bit converter still needs a 1-bit index port.
    function automatic int bit_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter must hold the larger of the two reload values (value-1),
    // one spare bit keeps the arithmetic simple.
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sar_conv_sequencer_if.sv
// Signal bundle between the conversion sequencer and its environment
// (requester, comparator, SAR register block, result consumer).
//   slave  : the sequencer side (takes start/op/om/result_ready, drives the rest)
//   master : the environment side
interface sar_conv_if import sar_ctrl_pkg::*; #(
    parameter int N_BITS = SAR_N_BITS
);
    localparam int BW = bit_idx_w(N_BITS);

    logic              start;
    logic              op;
    logic              om;
    logic              result_ready;
    logic              busy;
    logic              sample;
    logic              sar_rst;
    logic              sar_en;
    logic              comp_clk;
    logic [BW-1:0]     bit_idx;
    logic [N_BITS-1:0] result;
    logic              result_valid;
    logic              timeout_err;

    modport slave (
        input  start, op, om, result_ready,
        output busy, sample, sar_rst, sar_en, comp_clk, bit_idx,
               result, result_valid, timeout_err
    );

    modport master (
        output start, op, om, result_ready,
        input  busy, sample, sar_rst, sar_en, comp_clk, bit_idx,
               result, result_valid, timeout_err
    );

endinterface

// File: rtl/sar_ctrl_timer.sv
// Loadable down-counter shared by the track-phase duration and the
// comparator-decision timeout.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load_i      load value_i (has priority over dec_i)
//   value_i     reload value
//   dec_i       decrement by one; saturates at zero
//   zero_o      counter currently at zero
module sar_ctrl_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sar_conv_sequencer.sv
// Conversion controller for the SAR ADC: tracks the input, clears the SAR
// register block, strobes the comparator once per bit, packs the decisions
// and offers the word on a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (slave)         start/op/om/result_ready in;
//                       busy/sample/sar_rst/sar_en/comp_clk/bit_idx/
//                       result/result_valid/timeout_err out
// All outputs are decoded from registered state/counters (Moore).
module sar_conv_sequencer import sar_ctrl_pkg::*; #(
    parameter int N_BITS        = SAR_N_BITS,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
    parameter int TIMEOUT       = SAR_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    sar_conv_if.slave  bus
);

    localparam int BW = bit_idx_w(N_BITS);
    localparam int CW = BW + 1;
    localparam int TW = timer_w(SAMPLE_CYCLES, TIMEOUT);

    state_t            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              tout_q, tout_d;

    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic [TW-1:0]     tmr_val;

    logic              resolved;
    logic              last_bit;

    // A comparator decision is only trusted when the two outputs disagree.
    assign resolved = bus.op ^ bus.om;
    assign last_bit = (bit_cnt_q == CW'(N_BITS - 1));

    sar_ctrl_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and timer control
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SAMPLE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SAMPLE_CYCLES - 1);
                end
            end
            ST_SAMPLE: begin
                if (tmr_zero) begin
                    state_d = ST_ARM;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ARM: begin
                state_d  = ST_EVAL;
                tmr_load = 1'b1;
                tmr_val  = TW'(TIMEOUT - 1);
            end
            ST_EVAL: begin
                if (resolved) begin
                    state_d = last_bit ? ST_DONE : ST_ARM;
                end else if (tmr_zero) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result packing, bit counter and timeout flag
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        result_d  = result_q;
        tout_d    = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bit_cnt_d = '0;
                    result_d  = '0;
                    tout_d    = 1'b0;
                end
            end
            ST_EVAL: begin
                if (resolved) begin
                    result_d[bit_cnt_q[BW-1:0]] = bus.op;
                    // Index stays on the final bit so it never wraps.
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (tmr_zero) begin
                    tout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            result_q  <= '0;
            tout_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            result_q  <= result_d;
            tout_q    <= tout_d;
        end
    end

    // Output decode
    always_comb begin
        bus.busy         = (state_q != ST_IDLE);
        bus.sample       = (state_q == ST_SAMPLE);
        bus.sar_rst      = (state_q == ST_SAMPLE);
        // Enable/strobe drop in ARM so each bit gets exactly one capture.
        bus.sar_en       = (state_q == ST_EVAL);
        bus.comp_clk     = (state_q == ST_EVAL);
        bus.result_valid = (state_q == ST_DONE);
        bus.bit_idx      = bit_cnt_q[BW-1:0];
        bus.result       = result_q;
        bus.timeout_err  = tout_q;
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
module tb_sar_conv_sequencer;

    typedef struct {
        logic [7:0] dec;        // comparator decision per bit (op value)
        int         sbit;       // bit on which the comparator stalls
        int         scyc;       // number of unresolved EVAL cycles on sbit
        logic       skind;      // op=om value while stalled
        logic [7:0] exp_res;
        logic       exp_tout;
        int         exp_lat;
        int         exp_pulses;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_conv_if #(.N_BITS(8)) bus();

    sar_conv_sequencer #(
        .N_BITS        (8),
        .SAMPLE_CYCLES (4),
        .TIMEOUT       (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    vec_t tbl [8];
    vec_t sb [$];

    int   n_vec = 0;
    int   n_err = 0;
    int   lat, smp, pulses, stall_cnt;
    logic prev_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     32'(bus.busy),         0);
        check({tag, "_sample"},   32'(bus.sample),       0);
        check({tag, "_sar_rst"},  32'(bus.sar_rst),      0);
        check({tag, "_sar_en"},   32'(bus.sar_en),       0);
        check({tag, "_comp_clk"}, 32'(bus.comp_clk),     0);
        check({tag, "_bit_idx"},  32'(bus.bit_idx),      0);
        check({tag, "_result"},   32'(bus.result),       0);
        check({tag, "_valid"},    32'(bus.result_valid), 0);
        check({tag, "_tout"},     32'(bus.timeout_err),  0);
    endtask

    // Comparator model: resolves to v.dec[bit] unless stalling on v.sbit.
    task automatic model_step(input vec_t v);
        if (bus.comp_clk) begin
            if (int'(bus.bit_idx) == v.sbit && stall_cnt < v.scyc) begin
                bus.op = v.skind;
                bus.om = v.skind;
                stall_cnt++;
            end else begin
                bus.op = v.dec[bus.bit_idx];
                bus.om = ~v.dec[bus.bit_idx];
            end
        end else begin
            bus.op = 1'b0;
            bus.om = 1'b0;
        end
    endtask

    task automatic launch(input vec_t v, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        if (push) sb.push_back(v);
        lat = 0; smp = 0; pulses = 0; prev_en = 1'b0; stall_cnt = 0;
    endtask

    task automatic wait_done(input vec_t v, output bit got);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.sample) smp++;
            if (bus.sar_en && !prev_en) pulses++;
            prev_en = bus.sar_en;
            if (bus.result_valid) got = 1'b1;
            else model_step(v);
        end
        check("done_wait", 32'(got), 1);
    endtask

    task automatic score(input bit full);
        vec_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result",      32'(bus.result),      32'(e.exp_res));
            check("timeout_err", 32'(bus.timeout_err), 32'(e.exp_tout));
            if (full) begin
                check("latency",     32'(lat),    32'(e.exp_lat));
                check("sample_cyc",  32'(smp),    4);
                check("sar_en_puls", 32'(pulses), 32'(e.exp_pulses));
            end
        end
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check("rel_busy",  32'(bus.busy),         0);
        check("rel_valid", 32'(bus.result_valid), 0);
    endtask

    task automatic recover();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        bit got;
        bit hit;

        //           dec    sbit scyc kind  res    tout lat pulses
        tbl[0] = '{8'h55, 0,  0, 1'b0, 8'h55, 1'b0, 21, 8};  // nominal alternating
        tbl[1] = '{8'h08, 3,  5, 1'b0, 8'h08, 1'b0, 26, 8};  // slow comparator on bit 3
        tbl[2] = '{8'hFF, 2, 15, 1'b1, 8'h03, 1'b1, 25, 3};  // timeout on bit 2
        tbl[3] = '{8'hC3, 7,  2, 1'b1, 8'hC3, 1'b0, 23, 8};  // short stall, last bit
        tbl[4] = '{8'h00, 0, 14, 1'b1, 8'h00, 1'b0, 35, 8};  // one cycle short of timeout
        tbl[5] = '{8'hFF, 0, 15, 1'b0, 8'h00, 1'b1, 21, 1};  // timeout on first bit
        tbl[6] = '{8'hFF, 7, 15, 1'b1, 8'h7F, 1'b1, 35, 8};  // timeout on last bit
        tbl[7] = '{8'hA5, 0,  0, 1'b0, 8'hA5, 1'b0, 21, 8};  // nominal pattern 2

        // Reset with start and op asserted
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op = 1'b1;
        bus.om = 1'b0;
        bus.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        bus.start = 1'b0;
        bus.op = 1'b0;
        @(negedge clk);
        check("reset_stay_idle", 32'(bus.busy), 0);

        // Table-driven conversions
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i], 1'b1);
            wait_done(tbl[i], got);
            if (got) begin
                score(1'b1);
                release_result();
            end else begin
                recover();
            end
        end

        // Back-pressure: result held for 10 cycles, start pulses ignored
        launch(tbl[0], 1'b1);
        wait_done(tbl[0], got);
        if (got) begin
            score(1'b1);
            for (int k = 0; k < 10; k++) begin
                bus.start = (k % 2 == 0);
                @(negedge clk);
                check("bp_result", 32'(bus.result),       32'(tbl[0].exp_res));
                check("bp_valid",  32'(bus.result_valid), 1);
                check("bp_sample", 32'(bus.sample),       0);
            end
            bus.start = 1'b0;
            release_result();
        end else begin
            recover();
        end

        // start held high across DONE->IDLE: one idle cycle, then a new conversion
        launch(tbl[7], 1'b1);
        wait_done(tbl[7], got);
        if (got) begin
            score(1'b1);
            bus.start = 1'b1;
            bus.result_ready = 1'b1;
            sb.push_back(tbl[0]);
            @(negedge clk);
            bus.result_ready = 1'b0;
            check("held_gap_busy",   32'(bus.busy),   0);
            @(negedge clk);
            check("held_new_busy",   32'(bus.busy),   1);
            check("held_new_sample", 32'(bus.sample), 1);
            stall_cnt = 0; prev_en = 1'b0;
            wait_done(tbl[0], got);
            if (got) begin
                score(1'b0);
                release_result();
            end else begin
                recover();
            end
        end else begin
            recover();
        end

        // Abort during EVAL of bit 5, then a clean conversion
        launch(tbl[0], 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.comp_clk && int'(bus.bit_idx) == 5) hit = 1'b1;
            else model_step(tbl[0]);
        end
        check("abort_reach_bit5", 32'(hit), 1);
        check("abort_partial",    32'(bus.result), 32'h15);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        bus.op = 1'b0;
        bus.om = 1'b0;
        launch(tbl[3], 1'b1);
        wait_done(tbl[3], got);
        if (got) begin
            score(1'b1);
            release_result();
        end else begin
            recover();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
